fmc516_adc_spi_seq: RTL

//  Sequences the 3-wire SPI bus shared by the four FMC516 ADCs (CS adc1..adc4).

---
 rtl/fmc516_adc_spi_seq_if.sv | 21 ++
 rtl/fmc516_adc_spi_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc516_adc_spi_seq_if.sv
// Host register-access port of the FMC516 ADC SPI sequencer.
// master: register bank side (issues requests); slave: sequencer side.
interface fmc516_adc_spi_seq_if;
  logic        host_req_i;
  logic        host_rnw_i;
  logic [1:0]  host_sel_i;
  logic [12:0] host_addr_i;
  logic [7:0]  host_wdata_i;
  logic [7:0]  host_rdata_o;
  logic        host_ack_o;

  modport master (
    output host_req_i, host_rnw_i, host_sel_i, host_addr_i, host_wdata_i,
    input  host_rdata_o, host_ack_o
  );

  modport slave (
    input  host_req_i, host_rnw_i, host_sel_i, host_addr_i, host_wdata_i,
    output host_rdata_o, host_ack_o
  );
endinterface

// File: rtl/fmc516_adc_spi_seq.sv
// FMC516 ADC 3-wire SPI sequencer: power-up init table walk, then host
// register accesses, onto one bus shared by four ADC chip selects.
// Optional: FMC516_SPI_READBACK_VERIFY_EN adds a readback frame after each
// init write and flags mismatches on init_err_o.
module fmc516_adc_spi_seq #(
  parameter int unsigned g_clk_div  = 4,
  parameter int unsigned g_num_init = 8,
  parameter int unsigned g_cs_setup = 2
) (
  input  logic                 clk_sys_i,
  input  logic                 sys_rst_n_i,
  input  logic                 init_start_i,
  output logic [5:0]           init_addr_o,
  input  logic [25:0]          init_data_i,
  output logic                 init_done_o,
  output logic                 init_err_o,
  fmc516_adc_spi_seq_if.slave  host,
  output logic                 busy_o,
  output logic                 spi_sclk_o,
  output logic                 spi_sdo_o,
  output logic                 spi_sdo_oe_o,
  input  logic                 spi_sdi_i,
  output logic [3:0]           spi_cs_n_o
);

`ifdef FMC516_SPI_READBACK_VERIFY_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(2 * g_clk_div + g_cs_setup + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_GAP, ST_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic [23:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [3:0]  cs_n_q, cs_n_d;
  logic        oe_q, oe_d;
  logic [1:0]  sel_q, sel_d;
  logic        rd_q, rd_d;
  logic        src_init_q, src_init_d;
  logic        rb_q, rb_d;
  logic [5:0]  idx_q, idx_d;
  logic [20:0] ent_q, ent_d;
  logic        h_rnw_q, h_rnw_d;
  logic [12:0] h_addr_q, h_addr_d;
  logic [7:0]  h_wdata_q, h_wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Init entries are always sent as 1-byte writes, so R/W and length bits are ignored.
  logic unused_init_bits;
  assign unused_init_bits = ^init_data_i[23:21];

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_sys_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      cs_n_q     <= '1;
      oe_q       <= 1'b0;
      sel_q      <= '0;
      rd_q       <= 1'b0;
      src_init_q <= 1'b0;
      rb_q       <= 1'b0;
      idx_q      <= '0;
      ent_q      <= '0;
      h_rnw_q    <= 1'b0;
      h_addr_q   <= '0;
      h_wdata_q  <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      src_init_q <= src_init_d;
      rb_q       <= rb_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      h_rnw_q    <= h_rnw_d;
      h_addr_q   <= h_addr_d;
      h_wdata_q  <= h_wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Sequencer: arbitration, frame build, SCLK/SDO/SDI timing and init bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cs_n_d     = cs_n_q;
    oe_d       = oe_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    src_init_d = src_init_q;
    rb_d       = rb_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    h_rnw_d    = h_rnw_q;
    h_addr_d   = h_addr_q;
    h_wdata_d  = h_wdata_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (init_start_i) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          idx_d      = '0;
          src_init_d = 1'b1;
          rb_d       = 1'b0;
          state_d    = ST_FETCH;
        end else if (host.host_req_i) begin
          src_init_d = 1'b0;
          h_rnw_d    = host.host_rnw_i;
          sel_d      = host.host_sel_i;
          h_addr_d   = host.host_addr_i;
          h_wdata_d  = host.host_wdata_i;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (src_init_q && rb_q) begin
          tx_d = {1'b1, 2'b00, ent_q[20:8], 8'h00};
          rd_d = 1'b1;
        end else if (src_init_q) begin
          sel_d = init_data_i[25:24];
          ent_d = init_data_i[20:0];
          tx_d  = {1'b0, 2'b00, init_data_i[20:0]};
          rd_d  = 1'b0;
        end else begin
          tx_d = {h_rnw_q, 2'b00, h_addr_q, h_rnw_q ? 8'h00 : h_wdata_q};
          rd_d = h_rnw_q;
        end
        cs_n_d  = ~(4'b0001 << sel_d);
        oe_d    = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        rx_d    = '0;
        state_d = ST_CS_SETUP;
      end
      ST_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(g_cs_setup - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(g_clk_div - 1)) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], spi_sdi_i};
        end
        if (cnt_q == CNT_W'(2 * g_clk_div - 1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          tx_d   = {tx_q[22:0], 1'b0};
          bit_d  = bit_q + 5'd1;
          if (rd_q && bit_q == 5'd15) oe_d = 1'b0;
          if (bit_q == 5'd23) state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(g_cs_setup - 1)) begin
          cnt_d   = '0;
          cs_n_d  = '1;
          oe_d    = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (src_init_q) begin
          // A verified entry takes two frames; the index only moves after the readback.
          if (RB_EN && !rb_q) begin
            rb_d    = 1'b1;
            state_d = ST_FETCH;
          end else begin
            if (rb_q && rx_q != ent_q[7:0]) err_d = 1'b1;
            rb_d = 1'b0;
            if (idx_q == 6'(g_num_init - 1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = ST_FETCH;
            end
          end
        end else begin
          rdata_d = rd_q ? rx_q : 8'h00;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The table is registered, so it is addressed with the next index to have data during FETCH.
  assign init_addr_o       = idx_d;
  assign init_done_o       = done_q;
  assign init_err_o        = RB_EN & err_q;
  assign host.host_rdata_o = rdata_q;
  assign host.host_ack_o   = (state_q == ST_ACK);
  assign busy_o            = (state_q != ST_IDLE);
  assign spi_sclk_o        = sclk_q;
  assign spi_sdo_o         = tx_q[23] & ~(&cs_n_q);
  assign spi_sdo_oe_o      = oe_q;
  assign spi_cs_n_o        = cs_n_q;

endmodule
